// File: rtl/cache_config_pkg.sv
// Shared configuration for the associative L1D cache: FSM states and width helpers.
// Optional statistics counters are built when L1D_STATS_EN is defined.
package cache_config;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_LOOKUP    = 3'd1;
  localparam state_t S_WB        = 3'd2;
  localparam state_t S_FILL_REQ  = 3'd3;
  localparam state_t S_FILL_WAIT = 3'd4;

  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/l1d_lru.sv
// Per-set age-based LRU: age update on a touch and victim choice on a miss.
// Invalid ways are preferred as victims, lowest index first.
module l1d_lru
  import cache_config::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = clog2_int(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [WAYS-1:0]            valid,
  input  logic [AGE_W-1:0]           touch,
  output logic [WAYS-1:0][AGE_W-1:0] ages_next,
  output logic [AGE_W-1:0]           victim
);

  // touched way becomes youngest, younger ways age by one
  always_comb begin
    ages_next = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch) begin
        ages_next[w] = '0;
      end else if (ages[w] < ages[touch]) begin
        ages_next[w] = ages[w] + 1'b1;
      end
    end
  end

  // oldest way, overridden by the lowest invalid way
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = AGE_W'(w);
    end
  end

endmodule

// File: rtl/l1d_cache_assoc.sv
// Set-associative write-back L1 data cache with LRU replacement.
// Define L1D_STATS_EN to add saturating stat_hits / stat_misses counters.
module l1d_cache_assoc
  import cache_config::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int WAYS       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WORD_W-1:0]            req_wdata,
  output logic                         req_ready,
  output logic                         resp_valid,
  output logic [WORD_W-1:0]            resp_rdata,
  output logic                         hit,
  output logic                         miss,
  output logic                         mem_req_valid,
  output logic                         mem_req_write,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [WORD_W*LINE_WORDS-1:0] mem_req_wline,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_resp_rline
`ifdef L1D_STATS_EN
  ,
  output logic [31:0]                  stat_hits,
  output logic [31:0]                  stat_misses
`endif
);

  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int OFF_W  = clog2_int(LINE_WORDS);
  localparam int IDX_W  = clog2_int(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = clog2_int(WAYS);

  state_t              state;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WAY_W-1:0]    victim_q;

  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]   data_q  [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WAYS-1:0][WAY_W-1:0] age_q [SETS];

  logic [IDX_W-1:0]    idx;
  logic [OFF_W-1:0]    off;
  logic [TAG_W-1:0]    tag;
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic [LINE_W-1:0]   hit_line;
  logic [LINE_W-1:0]   merged;
  logic [WORD_W-1:0]   old_word;
  logic                lookup_hit;
  logic                lookup_miss;
  logic [WAYS-1:0][WAY_W-1:0] ages_next;
  logic [WAY_W-1:0]    lru_victim;

  assign idx = addr_q[OFF_W +: IDX_W];
  assign off = addr_q[OFF_W-1:0];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];

  // tag compare across the ways of the addressed set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line    = data_q[idx][hit_way];
  assign old_word    = hit_line[int'(off)*WORD_W +: WORD_W];
  assign lookup_hit  = (state == S_LOOKUP) && hit_any;
  assign lookup_miss = (state == S_LOOKUP) && !hit_any;

  // store data merged into the hit line
  always_comb begin
    merged = hit_line;
    merged[int'(off)*WORD_W +: WORD_W] = wdata_q;
  end

  l1d_lru #(
    .WAYS  (WAYS),
    .AGE_W (WAY_W)
  ) u_lru (
    .ages      (age_q[idx]),
    .valid     (valid_q[idx]),
    .touch     (hit_way),
    .ages_next (ages_next),
    .victim    (lru_victim)
  );

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = lookup_hit;
  assign hit        = lookup_hit;
  assign miss       = lookup_miss;
  assign resp_rdata = lookup_hit ? old_word : '0;

  // lower-level request drive, all zero when idle
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wline = '0;
    unique case (1'b1)
      (state == S_WB): begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
        mem_req_wline = data_q[idx][victim_q];
      end
      (state == S_FILL_REQ): begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag, idx, {OFF_W{1'b0}}};
      end
      default: ;
    endcase
  end

  // controller state, request latch and per-line status bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_any) begin
            age_q[idx] <= ages_next;
            if (wr_q) dirty_q[idx][hit_way] <= 1'b1;
            state <= S_IDLE;
          end else begin
            victim_q <= lru_victim;
            if (valid_q[idx][lru_victim] && dirty_q[idx][lru_victim])
              state <= S_WB;
            else
              state <= S_FILL_REQ;
          end
        end
        S_WB: begin
          if (mem_req_ready) begin
            dirty_q[idx][victim_q] <= 1'b0;
            state <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          if (mem_req_ready) state <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            state <= S_LOOKUP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // line data and tag storage: store merges and fill installs
  always_ff @(posedge clk) begin
    if (lookup_hit && wr_q) begin
      data_q[idx][hit_way] <= merged;
    end
    if (state == S_FILL_WAIT && mem_resp_valid) begin
      data_q[idx][victim_q] <= mem_resp_rline;
      tag_q[idx][victim_q]  <= tag;
    end
  end

`ifdef L1D_STATS_EN
  // saturating hit and miss pulse counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (lookup_hit && stat_hits != '1)
        stat_hits <= stat_hits + 1'b1;
      if (lookup_miss && stat_misses != '1)
        stat_misses <= stat_misses + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l1d_cache_assoc.sv
// Directed self-checking bench for l1d_cache_assoc (2 ways, 16 sets, 4-word lines).
// Stat counter checks are active when L1D_STATS_EN is defined.
module tb_l1d_cache_assoc;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_write;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          hit;
  logic          miss;
  logic          mem_req_valid;
  logic          mem_req_write;
  logic [31:0]   mem_req_addr;
  logic [127:0]  mem_req_wline;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [127:0]  mem_resp_rline;
`ifdef L1D_STATS_EN
  logic [31:0]   stat_hits;
  logic [31:0]   stat_misses;
`endif

  int checks   = 0;
  int failures = 0;

  l1d_cache_assoc dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .hit            (hit),
    .miss           (miss),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wline  (mem_req_wline),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rline (mem_resp_rline)
`ifdef L1D_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // present a request in IDLE; returns in the LOOKUP cycle
  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    chk("req_ready_idle", 128'(req_ready), 128'(1'b1));
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
  endtask

  // LOOKUP cycle with a hit; returns in the following IDLE cycle
  task automatic expect_hit(input string name, input logic [31:0] data);
    chk({name, "_flags"}, 128'({resp_valid, hit, miss}), 128'(3'b110));
    chk({name, "_rdata"}, 128'(resp_rdata), 128'(data));
    @(negedge clk);
  endtask

  // LOOKUP cycle with a miss; returns in WB or FILL_REQ
  task automatic expect_miss(input string name);
    chk({name, "_flags"}, 128'({resp_valid, hit, miss}), 128'(3'b001));
    @(negedge clk);
  endtask

  // writeback accepted at once; returns in FILL_REQ
  task automatic serve_wb(input logic [31:0] a, input logic [127:0] line);
    chk("wb_req", 128'({mem_req_valid, mem_req_write, mem_req_addr}),
        128'({2'b11, a}));
    chk("wb_line", mem_req_wline, line);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask

  // fill request then response; returns in the LOOKUP cycle
  task automatic serve_fill(input logic [31:0] a, input logic [127:0] line);
    chk("fill_req", 128'({mem_req_valid, mem_req_write, mem_req_addr}),
        128'({2'b10, a}));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("fill_wait_idle_bus",
        128'({mem_req_valid, mem_req_write, mem_req_addr}), 128'(0));
    mem_resp_valid = 1'b1;
    mem_resp_rline = line;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rline = '0;
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rline = '0;
    repeat (2) @(negedge clk);

    chk("reset_outputs",
        128'({req_ready, resp_valid, hit, miss, mem_req_valid,
              mem_req_write}), 128'(6'b100000));
    chk("reset_addr_data",
        128'({mem_req_addr, resp_rdata}), 128'(0));
    chk("reset_wline", mem_req_wline, 128'(0));
`ifdef L1D_STATS_EN
    chk("reset_stats", 128'({stat_hits, stat_misses}), 128'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    // cold load 0x41 -> fill 0x40 with {4,3,2,1}
    issue(1'b0, 32'h41, '0);
    expect_miss("cold_miss");
    serve_fill(32'h40, 128'h00000004_00000003_00000002_00000001);
    expect_hit("cold_reload", 32'h2);

    // store hit returns old word, then load sees new word
    issue(1'b1, 32'h41, 32'hAA);
    expect_hit("store_hit", 32'h2);
    issue(1'b0, 32'h41, '0);
    expect_hit("load_after_store", 32'hAA);

    // second conflicting line fills the invalid way
    issue(1'b1, 32'h80, 32'h11);
    expect_miss("st80_miss");
    serve_fill(32'h80, 128'h00000084_00000083_00000082_00000081);
    expect_hit("st80_hit", 32'h81);

    // third conflicting line evicts dirty 0x40; memory stalls 5 cycles
    issue(1'b1, 32'hC0, 32'h22);
    expect_miss("stC0_miss");
    for (int i = 0; i < 5; i++) begin
      chk("wb_stall", 128'({mem_req_valid, mem_req_write, mem_req_addr}),
          128'({2'b11, 32'h40}));
      @(negedge clk);
    end
    serve_wb(32'h40, 128'h00000004_00000003_000000AA_00000001);
    serve_fill(32'hC0, 128'h000000C4_000000C3_000000C2_000000C1);
    expect_hit("stC0_hit", 32'hC1);

    // both resident lines hit; 0x80 becomes most recent
    issue(1'b0, 32'hC0, '0);
    expect_hit("ldC0", 32'h22);
    issue(1'b0, 32'h80, '0);
    expect_hit("ld80", 32'h11);

    // reload 0x41 evicts least-recent dirty 0xC0
    issue(1'b0, 32'h41, '0);
    expect_miss("ld41_miss");
    serve_wb(32'hC0, 128'h000000C4_000000C3_000000C2_00000022);
    serve_fill(32'h40, 128'h00000004_00000003_000000AA_00000001);
    expect_hit("ld41_refill", 32'hAA);

    // load 0x100 evicts dirty 0x80, then reset lands in FILL_WAIT
    issue(1'b0, 32'h102, '0);
    expect_miss("ld100_miss");
    serve_wb(32'h80, 128'h00000084_00000083_00000082_00000011);
    chk("fill100_req", 128'({mem_req_valid, mem_req_write, mem_req_addr}),
        128'({2'b10, 32'h100}));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
`ifdef L1D_STATS_EN
    chk("stats_before_reset", 128'({stat_hits, stat_misses}),
        128'({32'd8, 32'd5}));
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs",
        128'({req_ready, resp_valid, hit, miss, mem_req_valid}),
        128'(5'b10000));
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rline = 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rline = '0;
    chk("late_resp_ignored",
        128'({req_ready, resp_valid, hit, mem_req_valid}), 128'(4'b1000));

    // same address misses again after reset
    issue(1'b0, 32'h102, '0);
    expect_miss("post_reset_miss");
    serve_fill(32'h100, 128'h00000104_00000103_00000102_00000101);
    expect_hit("post_reset_hit", 32'h103);
    @(negedge clk);
`ifdef L1D_STATS_EN
    chk("stats_after_reset", 128'({stat_hits, stat_misses}),
        128'({32'd1, 32'd1}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
